// File: rtl/scaler_frame_ctl.sv
// Frame sequencer for the bilinear scaler: double-buffered geometry, fsync
// generation and passive framing/stall/overrun monitoring of the output stream.
module scaler_frame_ctl #(
  parameter int C_SW_WIDTH   = 10,
  parameter int C_SH_WIDTH   = 10,
  parameter int C_MW_WIDTH   = 10,
  parameter int C_MH_WIDTH   = 10,
  parameter int C_TO_WIDTH   = 24,
  parameter int C_FCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [C_SW_WIDTH-1:0]   cfg_s_width,
  input  logic [C_SH_WIDTH-1:0]   cfg_s_height,
  input  logic [C_MW_WIDTH-1:0]   cfg_m_width,
  input  logic [C_MH_WIDTH-1:0]   cfg_m_height,
  input  logic                    cfg_update,
  input  logic [C_TO_WIDTH-1:0]   timeout_cycles,
  input  logic                    frm_start,
  output logic                    fsync,
  output logic [C_SW_WIDTH-1:0]   s_width,
  output logic [C_SH_WIDTH-1:0]   s_height,
  output logic [C_MW_WIDTH-1:0]   m_width,
  output logic [C_MH_WIDTH-1:0]   m_height,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tuser,
  input  logic                    mon_tlast,
  output logic                    busy,
  output logic                    frm_done,
  output logic [C_FCNT_WIDTH-1:0] frm_cnt,
  input  logic                    err_clr,
  output logic                    err_cfg,
  output logic                    err_sof,
  output logic                    err_eol,
  output logic                    err_timeout,
  output logic                    err_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SYNC = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [C_MW_WIDTH-1:0]   MW_ONE = {{(C_MW_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_MH_WIDTH-1:0]   MH_ONE = {{(C_MH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_TO_WIDTH-1:0]   TO_ONE = {{(C_TO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_FCNT_WIDTH-1:0] FC_ONE = {{(C_FCNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [C_SW_WIDTH-1:0]   sh_sw_r, act_sw_r;
  logic [C_SH_WIDTH-1:0]   sh_sh_r, act_sh_r;
  logic [C_MW_WIDTH-1:0]   sh_mw_r, act_mw_r, col_r;
  logic [C_MH_WIDTH-1:0]   sh_mh_r, act_mh_r, row_r;
  logic [C_TO_WIDTH-1:0]   stall_r;
  logic [C_FCNT_WIDTH-1:0] frm_cnt_r;
  logic pending_r, valid_r;
  logic fsync_r, busy_r, frm_done_r;
  logic err_cfg_r, err_sof_r, err_eol_r, err_timeout_r, err_overrun_r;

  logic cfg_ok_s, cfg_bad_s, beat_s, col_last_s, row_last_s, final_s, timeout_s;
  logic sof_bad_s, eol_bad_s;
  logic commit_s, done_s, overrun_s, to_err_s;

  assign cfg_ok_s   = cfg_update && (cfg_s_width != '0) && (cfg_s_height != '0) &&
                      (cfg_m_width != '0) && (cfg_m_height != '0);
  assign cfg_bad_s  = cfg_update && !cfg_ok_s;
  assign beat_s     = (state_r == ST_RUN) && mon_tvalid && mon_tready;
  assign col_last_s = (col_r == (act_mw_r - MW_ONE));
  assign row_last_s = (row_r == (act_mh_r - MH_ONE));
  assign final_s    = beat_s && col_last_s && row_last_s;
  assign timeout_s  = (state_r == ST_RUN) && !beat_s && (timeout_cycles != '0) &&
                      (stall_r == timeout_cycles);
  // Framing is judged against the internal position, never the monitored flags
  assign sof_bad_s  = beat_s && (mon_tuser != ((row_r == '0) && (col_r == '0)));
  assign eol_bad_s  = beat_s && (mon_tlast != col_last_s);

  // Next-state decode and per-cycle frame events
  always_comb begin
    state_s   = state_r;
    commit_s  = 1'b0;
    done_s    = 1'b0;
    overrun_s = 1'b0;
    to_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && valid_r) state_s = ST_WAIT;
        else                   state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (frm_start) begin
          commit_s = 1'b1;
          state_s  = ST_SYNC;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SYNC: begin
        if (frm_start) begin
          overrun_s = 1'b1;
          commit_s  = 1'b1;
          state_s   = ST_SYNC;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (final_s) begin
          done_s = 1'b1;
          if (!enable) begin
            state_s = ST_IDLE;
          end else if (frm_start) begin
            commit_s = 1'b1;
            state_s  = ST_SYNC;
          end else begin
            state_s = ST_WAIT;
          end
        end else if (frm_start) begin
          overrun_s = 1'b1;
          commit_s  = 1'b1;
          state_s   = ST_SYNC;
        end else if (timeout_s) begin
          to_err_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      fsync_r    <= 1'b0;
      busy_r     <= 1'b0;
      frm_done_r <= 1'b0;
      frm_cnt_r  <= '0;
    end else begin
      state_r    <= state_s;
      fsync_r    <= (state_s == ST_SYNC);
      busy_r     <= (state_s == ST_SYNC) || (state_s == ST_RUN);
      frm_done_r <= done_s;
      if (done_s) frm_cnt_r <= frm_cnt_r + FC_ONE;
    end
  end

  // Shadow capture and frame-boundary commit; commit reads the old shadow
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_sw_r   <= '0;
      sh_sh_r   <= '0;
      sh_mw_r   <= '0;
      sh_mh_r   <= '0;
      act_sw_r  <= '0;
      act_sh_r  <= '0;
      act_mw_r  <= '0;
      act_mh_r  <= '0;
      pending_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      if (commit_s && pending_r) begin
        act_sw_r <= sh_sw_r;
        act_sh_r <= sh_sh_r;
        act_mw_r <= sh_mw_r;
        act_mh_r <= sh_mh_r;
      end
      if (cfg_ok_s) begin
        sh_sw_r   <= cfg_s_width;
        sh_sh_r   <= cfg_s_height;
        sh_mw_r   <= cfg_m_width;
        sh_mh_r   <= cfg_m_height;
        pending_r <= 1'b1;
        valid_r   <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Output-beat position and stall counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_r   <= '0;
      row_r   <= '0;
      stall_r <= '0;
    end else if (commit_s) begin
      col_r   <= '0;
      row_r   <= '0;
      stall_r <= '0;
    end else if (state_r == ST_RUN) begin
      if (beat_s) begin
        stall_r <= '0;
        if (col_last_s) begin
          col_r <= '0;
          row_r <= row_last_s ? '0 : (row_r + MH_ONE);
        end else begin
          col_r <= col_r + MW_ONE;
        end
      end else begin
        stall_r <= stall_r + TO_ONE;
      end
    end else begin
      stall_r <= '0;
    end
  end

  // Sticky error flags; a new event outranks err_clr
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_cfg_r     <= 1'b0;
      err_sof_r     <= 1'b0;
      err_eol_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      err_cfg_r     <= cfg_bad_s | (err_cfg_r     & ~err_clr);
      err_sof_r     <= sof_bad_s | (err_sof_r     & ~err_clr);
      err_eol_r     <= eol_bad_s | (err_eol_r     & ~err_clr);
      err_timeout_r <= to_err_s  | (err_timeout_r & ~err_clr);
      err_overrun_r <= overrun_s | (err_overrun_r & ~err_clr);
    end
  end

  assign fsync       = fsync_r;
  assign busy        = busy_r;
  assign frm_done    = frm_done_r;
  assign frm_cnt     = frm_cnt_r;
  assign s_width     = act_sw_r;
  assign s_height    = act_sh_r;
  assign m_width     = act_mw_r;
  assign m_height    = act_mh_r;
  assign err_cfg     = err_cfg_r;
  assign err_sof     = err_sof_r;
  assign err_eol     = err_eol_r;
  assign err_timeout = err_timeout_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_scaler_frame_ctl.sv
// Self-checking bench for scaler_frame_ctl: directed scenarios plus a random
// stream compared every cycle against a frame-level reference model.
module tb_scaler_frame_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, enable, cfg_update, frm_start, err_clr;
  logic [9:0]  cfg_s_width, cfg_s_height, cfg_m_width, cfg_m_height;
  logic [23:0] timeout_cycles;
  logic        mon_tvalid, mon_tready, mon_tuser, mon_tlast;
  logic        fsync, busy, frm_done;
  logic [9:0]  s_width, s_height, m_width, m_height;
  logic [15:0] frm_cnt;
  logic        err_cfg, err_sof, err_eol, err_timeout, err_overrun;
  logic [4:0]  errs;
  int total = 0;
  int bad = 0;

  assign errs = {err_cfg, err_sof, err_eol, err_timeout, err_overrun};

  scaler_frame_ctl dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .cfg_s_width(cfg_s_width), .cfg_s_height(cfg_s_height),
    .cfg_m_width(cfg_m_width), .cfg_m_height(cfg_m_height),
    .cfg_update(cfg_update), .timeout_cycles(timeout_cycles),
    .frm_start(frm_start), .fsync(fsync),
    .s_width(s_width), .s_height(s_height), .m_width(m_width), .m_height(m_height),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
    .busy(busy), .frm_done(frm_done), .frm_cnt(frm_cnt), .err_clr(err_clr),
    .err_cfg(err_cfg), .err_sof(err_sof), .err_eol(err_eol),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  // Reference model: mode 0 idle, 1 wait, 2 sync, 3 run; frame position is a flat beat index
  int md_mode, md_bidx, md_stall, md_frames;
  int sh_g[4];
  int ac_g[4];
  bit md_have, md_pend, md_fsync, md_busy, md_done;
  bit [4:0] md_err;

  task automatic model_reset();
    md_mode = 0; md_bidx = 0; md_stall = 0; md_frames = 0;
    for (int i = 0; i < 4; i++) begin sh_g[i] = 0; ac_g[i] = 0; end
    md_have = 0; md_pend = 0; md_fsync = 0; md_busy = 0; md_done = 0; md_err = '0;
  endtask

  task automatic model_step();
    bit beat, last, hit, commit;
    int nmode;
    bit [4:0] ev;
    if (!resetn) begin
      model_reset();
      return;
    end
    ev = '0; commit = 0; md_done = 0; nmode = md_mode;
    beat = (md_mode == 3) && mon_tvalid && mon_tready;
    last = beat && (md_bidx == ac_g[2] * ac_g[3] - 1);
    hit  = (md_mode == 3) && !beat && (timeout_cycles != 0) && (md_stall == timeout_cycles);
    if (beat) begin
      if (mon_tuser != (md_bidx == 0)) ev[3] = 1;
      if (mon_tlast != ((md_bidx % ac_g[2]) == ac_g[2] - 1)) ev[2] = 1;
    end
    case (md_mode)
      0: if (enable && md_have) nmode = 1;
      1: if (!enable) nmode = 0;
         else if (frm_start) begin commit = 1; nmode = 2; end
      2: begin
        nmode = 3;
        if (frm_start) begin ev[0] = 1; commit = 1; nmode = 2; end
      end
      default: begin
        if (last) begin
          md_done = 1; md_frames++;
          nmode = !enable ? 0 : (frm_start ? 2 : 1);
          commit = enable && frm_start;
        end else if (frm_start) begin
          ev[0] = 1; commit = 1; nmode = 2;
        end else if (hit) begin
          ev[1] = 1; nmode = 1;
        end
      end
    endcase
    if (commit) begin
      if (md_pend) for (int i = 0; i < 4; i++) ac_g[i] = sh_g[i];
      md_pend = 0; md_bidx = 0; md_stall = 0;
    end else if (md_mode == 3) begin
      if (beat) begin md_bidx = last ? 0 : md_bidx + 1; md_stall = 0; end
      else md_stall++;
    end else begin
      md_stall = 0;
    end
    if (cfg_update) begin
      if (cfg_s_width != 0 && cfg_s_height != 0 && cfg_m_width != 0 && cfg_m_height != 0) begin
        sh_g[0] = cfg_s_width; sh_g[1] = cfg_s_height;
        sh_g[2] = cfg_m_width; sh_g[3] = cfg_m_height;
        md_pend = 1; md_have = 1;
      end else begin
        ev[4] = 1;
      end
    end
    md_err = ev | (md_err & {5{!err_clr}});
    md_mode = nmode;
    md_fsync = (nmode == 2);
    md_busy = (nmode >= 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_frame();
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
  endtask

  task automatic send_beats(input int mw, input int first, input int n, input int eol_bad, input bit sof_bad);
    for (int i = first; i < first + n; i++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tuser  = (i == 0) && !sof_bad;
      mon_tlast  = ((i % mw) == mw - 1) || (i == eol_bad);
      tick();
    end
    mon_tvalid = 1'b0;
    mon_tuser  = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic set_cfg(input int sw, input int sh, input int mw, input int mh);
    cfg_s_width = 10'(sw); cfg_s_height = 10'(sh);
    cfg_m_width = 10'(mw); cfg_m_height = 10'(mh);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  task automatic test_reset();
    logic [65:0] obs;
    resetn = 1'b0;
    tick(); tick();
    obs = {fsync, busy, frm_done, errs, s_width, s_height, m_width, m_height, frm_cnt, 1'b0};
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_state: got %h want 0", obs); end
    resetn = 1'b1;
    tick();
    total++;
    if ({fsync, busy, frm_done, errs} !== 8'h00) begin
      bad++; $display("FAIL reset_release: got %b want 0", {fsync, busy, frm_done, errs});
    end
  endtask

  task automatic test_no_cfg();
    bit seen;
    seen = 0;
    enable = 1'b1;
    start_frame();
    for (int i = 0; i < 4; i++) begin
      if (fsync || busy) seen = 1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("FAIL no_cfg_start: fsync/busy seen=1 want 0"); end
  endtask

  task automatic test_basic();
    set_cfg(8, 4, 4, 2);
    tick();
    start_frame();
    total++;
    if (fsync !== 1'b1 || busy !== 1'b1 || {s_width, s_height, m_width, m_height} !== {10'd8, 10'd4, 10'd4, 10'd2}) begin
      bad++; $display("FAIL basic_sync: fsync=%b busy=%b geo=%0d/%0d/%0d/%0d want 1 1 8/4/4/2",
                      fsync, busy, s_width, s_height, m_width, m_height);
    end
    tick();
    total++;
    if (fsync !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_run: fsync=%b busy=%b want 0 1", fsync, busy);
    end
    send_beats(4, 0, 8, -1, 0);
    total++;
    if (frm_done !== 1'b1 || frm_cnt !== 16'd1 || errs !== 5'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done: done=%b cnt=%0d errs=%b busy=%b want 1 1 0 0", frm_done, frm_cnt, errs, busy);
    end
    tick();
    total++;
    if (frm_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: done=%b want 0", frm_done); end
  endtask

  task automatic test_shadow();
    start_frame(); tick();
    send_beats(4, 0, 3, -1, 0);
    set_cfg(8, 4, 6, 2);
    total++;
    if (m_width !== 10'd4) begin bad++; $display("FAIL shadow_hold: m_width=%0d want 4", m_width); end
    send_beats(4, 3, 5, -1, 0);
    total++;
    if (frm_done !== 1'b1 || m_width !== 10'd4) begin
      bad++; $display("FAIL shadow_frame1: done=%b m_width=%0d want 1 4", frm_done, m_width);
    end
    start_frame();
    total++;
    if (fsync !== 1'b1 || m_width !== 10'd6) begin
      bad++; $display("FAIL shadow_commit: fsync=%b m_width=%0d want 1 6", fsync, m_width);
    end
    tick();
    send_beats(6, 0, 12, -1, 0);
    total++;
    if (frm_done !== 1'b1 || errs !== 5'd0 || frm_cnt !== 16'd3) begin
      bad++; $display("FAIL shadow_frame2: done=%b errs=%b cnt=%0d want 1 0 3", frm_done, errs, frm_cnt);
    end
  endtask

  task automatic test_framing();
    set_cfg(8, 4, 4, 2);
    start_frame(); tick();
    send_beats(4, 0, 8, 2, 0);
    total++;
    if (err_eol !== 1'b1 || err_sof !== 1'b0 || frm_done !== 1'b1) begin
      bad++; $display("FAIL framing_eol: eol=%b sof=%b done=%b want 1 0 1", err_eol, err_sof, frm_done);
    end
    start_frame(); tick();
    send_beats(4, 0, 8, -1, 1);
    total++;
    if (err_sof !== 1'b1 || frm_done !== 1'b1) begin
      bad++; $display("FAIL framing_sof: sof=%b done=%b want 1 1", err_sof, frm_done);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++;
    if (err_sof !== 1'b0 || err_eol !== 1'b0) begin
      bad++; $display("FAIL framing_clr: sof=%b eol=%b want 0 0", err_sof, err_eol);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen_done;
    timeout_cycles = 24'd20;
    start_frame(); tick();
    send_beats(4, 0, 4, -1, 0);
    n = 0; seen_done = 0;
    while (!err_timeout && n < 40) begin
      tick(); n++;
      if (frm_done) seen_done = 1;
    end
    total++;
    if (n != 21) begin bad++; $display("FAIL timeout_latency: cycles=%0d want 21", n); end
    total++;
    if (busy !== 1'b0 || seen_done) begin
      bad++; $display("FAIL timeout_abort: busy=%b done_seen=%b want 0 0", busy, seen_done);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    timeout_cycles = 24'd0;
    start_frame(); tick();
    send_beats(4, 0, 4, -1, 0);
    repeat (40) tick();
    total++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_disabled: err=%b busy=%b want 0 1", err_timeout, busy);
    end
    send_beats(4, 4, 4, -1, 0);
    total++;
    if (frm_done !== 1'b1) begin bad++; $display("FAIL timeout_resume: done=%b want 1", frm_done); end
  endtask

  task automatic test_overrun();
    start_frame(); tick();
    send_beats(4, 0, 5, -1, 0);
    frm_start = 1'b1;
    send_beats(4, 5, 1, -1, 0);
    frm_start = 1'b0;
    total++;
    if (err_overrun !== 1'b1 || fsync !== 1'b1 || frm_done !== 1'b0) begin
      bad++; $display("FAIL overrun_flag: ovr=%b fsync=%b done=%b want 1 1 0", err_overrun, fsync, frm_done);
    end
    tick();
    send_beats(4, 0, 8, -1, 0);
    total++;
    if (frm_done !== 1'b1 || err_sof !== 1'b0 || err_eol !== 1'b0) begin
      bad++; $display("FAIL overrun_restart: done=%b sof=%b eol=%b want 1 0 0", frm_done, err_sof, err_eol);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    start_frame(); tick();
    send_beats(4, 0, 7, -1, 0);
    frm_start = 1'b1;
    send_beats(4, 7, 1, -1, 0);
    frm_start = 1'b0;
    total++;
    if (frm_done !== 1'b1 || fsync !== 1'b1 || err_overrun !== 1'b0 || frm_cnt !== 16'(md_frames)) begin
      bad++; $display("FAIL coincident_start: done=%b fsync=%b ovr=%b cnt=%0d want 1 1 0 %0d",
                      frm_done, fsync, err_overrun, frm_cnt, md_frames);
    end
    tick();
    send_beats(4, 0, 8, -1, 0);
    total++;
    if (frm_done !== 1'b1) begin bad++; $display("FAIL coincident_next: done=%b want 1", frm_done); end
  endtask

  task automatic test_invalid_cfg();
    set_cfg(8, 4, 4, 0);
    total++;
    if (err_cfg !== 1'b1 || m_height !== 10'd2) begin
      bad++; $display("FAIL cfg_reject: err_cfg=%b m_height=%0d want 1 2", err_cfg, m_height);
    end
    cfg_m_width = 10'd5;
    start_frame();
    total++;
    if (fsync !== 1'b1 || m_width !== 10'd4 || m_height !== 10'd2) begin
      bad++; $display("FAIL cfg_keep: fsync=%b geo=%0dx%0d want 1 4x2", fsync, m_width, m_height);
    end
    tick();
    send_beats(4, 0, 8, -1, 0);
    total++;
    if (frm_done !== 1'b1 || err_eol !== 1'b0) begin
      bad++; $display("FAIL cfg_keep_frame: done=%b eol=%b want 1 0", frm_done, err_eol);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_frame(); tick();
    send_beats(4, 0, 3, -1, 0);
    resetn = 1'b0;
    tick();
    total++;
    if ({fsync, busy, frm_done, errs, frm_cnt, m_width, m_height} !== '0) begin
      bad++; $display("FAIL reset_mid: busy=%b cnt=%0d geo=%0dx%0d want all 0", busy, frm_cnt, m_width, m_height);
    end
    resetn = 1'b1;
    start_frame();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (fsync || busy || frm_done) seen = 1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("FAIL reset_no_cfg: fsync/busy/done seen=1 want 0"); end
  endtask

  task automatic test_random();
    logic [63:0] obs, expv;
    int mw;
    set_cfg(1 + $urandom_range(0, 50), 1 + $urandom_range(0, 50), 3, 2);
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) timeout_cycles = ($urandom_range(0, 2) == 0) ? 24'd0 : 24'($urandom_range(3, 8));
      resetn = ($urandom_range(0, 999) >= 3);
      if ($urandom_range(0, 99) < 1) enable = ~enable;
      frm_start = ($urandom_range(0, 99) < 4);
      err_clr = ($urandom_range(0, 99) < 3);
      cfg_update = ($urandom_range(0, 99) < 3);
      cfg_s_width  = 10'($urandom_range(1, 1023));
      cfg_s_height = 10'($urandom_range(1, 1023));
      cfg_m_width  = 10'($urandom_range(1, 5));
      cfg_m_height = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 3));
      mw = (ac_g[2] == 0) ? 1 : ac_g[2];
      mon_tvalid = ($urandom_range(0, 99) < 70);
      mon_tready = ($urandom_range(0, 99) < 85);
      mon_tuser  = (md_bidx == 0) ^ ($urandom_range(0, 99) < 3);
      mon_tlast  = ((md_bidx % mw) == mw - 1) ^ ($urandom_range(0, 99) < 3);
      tick();
      obs  = {fsync, busy, frm_done, errs, s_width, s_height, m_width, m_height, frm_cnt};
      expv = {md_fsync, md_busy, md_done, md_err, 10'(ac_g[0]), 10'(ac_g[1]),
              10'(ac_g[2]), 10'(ac_g[3]), 16'(md_frames)};
      total++;
      if (obs !== expv) begin
        bad++;
        if (bad < 20) $display("FAIL random cycle %0d: got %h want %h", c, obs, expv);
      end
    end
    resetn = 1'b1; frm_start = 1'b0; err_clr = 1'b0; cfg_update = 1'b0; mon_tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    resetn = 1'b0; enable = 1'b0; cfg_update = 1'b0; frm_start = 1'b0; err_clr = 1'b0;
    cfg_s_width = '0; cfg_s_height = '0; cfg_m_width = '0; cfg_m_height = '0;
    timeout_cycles = '0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
    test_reset();
    test_no_cfg();
    test_basic();
    test_shadow();
    test_framing();
    test_timeout();
    test_overrun();
    test_invalid_cfg();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scaler_frame_ctl.md
# scaler_frame_ctl

Frame-level sequencer for the AXI-Stream bilinear scaler. It double-buffers the source/destination geometry and commits a new geometry only at frame boundaries. It issues the scaler's one-cycle `fsync` frame restart and passively monitors the scaler's output stream. From that monitoring it reports frame completion, framing violations, stalls and overruns. It sits between the register/control plane and the scaler; it never drives data or ready.

## Interface
- `C_SW_WIDTH`, default 10: source width field width.
- `C_SH_WIDTH`, default 10: source height field width.
- `C_MW_WIDTH`, default 10: output width field width.
- `C_MH_WIDTH`, default 10: output height field width.
- `C_TO_WIDTH`, default 24: stall timeout counter width.
- `C_FCNT_WIDTH`, default 16: completed-frame counter width.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `enable`  in  1  controller enable; level.
- `cfg_s_width` / `cfg_s_height` / `cfg_m_width` / `cfg_m_height`  in  C_SW/SH/MW/MH_WIDTH  requested geometry.
- `cfg_update`  in  1  pulse; sample `cfg_*` into shadow.
- `timeout_cycles`  in  C_TO_WIDTH  stall limit; 0 disables the timeout.
- `frm_start`  in  1  pulse; upstream start-of-frame request.
- `fsync`  out  1  one-cycle frame restart to the scaler.
- `s_width` / `s_height` / `m_width` / `m_height`  out  as cfg  active geometry to the scaler.
- `mon_tvalid`, `mon_tready`, `mon_tuser`, `mon_tlast`  in  1 each  taps of the scaler output AXIS.
- `busy`  out  1  state is SYNC or RUN.
- `frm_done`  out  1  one-cycle pulse on the final output beat of a frame.
- `frm_cnt`  out  C_FCNT_WIDTH  completed frames; wraps.
- `err_clr`  in  1  pulse; clears all sticky errors.
- `err_cfg`, `err_sof`, `err_eol`, `err_timeout`, `err_overrun`  out  1  sticky error flags.

## Operation
- **Shadow update:**
  - On `cfg_update`, if all four `cfg_*` fields are nonzero, the controller loads the shadow and sets `pending`.
  - Otherwise it sets `err_cfg`; the shadow and `pending` are unchanged.
- **States:** IDLE, WAIT, SYNC, RUN.
- **IDLE:**
  - Go to WAIT when `enable`=1 and a valid shadow exists, i.e. at least one accepted update since reset.
- **WAIT:**
  - `enable`=0 returns to IDLE.
  - `frm_start` does: active geometry ← shadow if `pending`; clear `pending`; clear counters; go to SYNC.
- **SYNC** (exactly 1 cycle):
  - Assert `fsync`, then go to RUN.
- **RUN:**
  - Each beat is `mon_tvalid & mon_tready`; it advances `col` over 0..m_width-1 and `row` over 0..m_height-1.
  - Expected `tuser` is 1 only at (row 0, col 0). Expected `tlast` is 1 only at col = m_width-1.
  - A mismatch sets `err_sof` or `err_eol` respectively. Counting continues using the internal counters, not the monitored flags.
  - The beat at (m_height-1, m_width-1) pulses `frm_done` and increments `frm_cnt`. The next state is WAIT, or IDLE if `enable`=0.
- **Stall timeout:**
  - The stall counter clears on every beat and on entry to RUN, and increments otherwise in RUN.
  - When it equals a nonzero `timeout_cycles`: set `err_timeout`, abort the frame (no `frm_done`), go to WAIT.
- **Overrun:**
  - `frm_start` in SYNC or RUN sets `err_overrun` and abandons the frame (no `frm_done`).
  - It performs the WAIT commit actions and goes to SYNC.
- **Enable drop:**
  - `enable` dropping in SYNC or RUN does not abort; the frame completes first.
- **Error flags:** sticky. `err_clr` clears them; a set event in the same cycle wins over `err_clr`.
- **Counter widths:** `col`/`row` are sized C_MW_WIDTH / C_MH_WIDTH. `frm_cnt` wraps modulo 2^C_FCNT_WIDTH.

## Timing
- **Reset values:** state IDLE. `fsync`, `busy`, `frm_done` are 0. Active geometry, shadow, `pending` and `frm_cnt` are 0. All errors 0; valid-shadow flag 0.
- **fsync:** `frm_start` sampled in WAIT at cycle N gives `fsync`=1 at N+1 and RUN from N+2.
- **Active geometry:** updates at N+1, together with `fsync`, and is stable until the next SYNC. It is never changed mid-frame.
- **frm_done / frm_cnt:** `frm_done` and the `frm_cnt` increment are registered, visible the cycle after the final beat.
- **Error flags:** register the cycle after the offending beat or timeout.
- **Simultaneous final beat and `frm_start` in RUN:** the frame completes (`frm_done`, `frm_cnt`+1, no overrun). The `frm_start` is honoured as in WAIT, with `fsync` at the next cycle.
- **Simultaneous `cfg_update` and `frm_start` in WAIT:** the commit uses the previous shadow; the new values stay pending for the next frame.
- **Reset mid-frame:** `resetn`=0 returns all state to reset values within one cycle. No `fsync` or `frm_done` is produced.

## Test plan
- **Basic frame:** cfg 8x4→4x2, `cfg_update`, `enable`, `frm_start`, 8 clean beats (tuser on beat 0, tlast on beats 3 and 7) → `fsync` 1 cycle after start, `frm_done` after beat 7, `frm_cnt`=1, no errors.
- **Shadow isolation:** mid-RUN `cfg_update` to m_width=6 → `m_width` output stays 4 until the next `fsync`, then becomes 6; the second frame expects 6-beat lines.
- **Framing errors:** tlast on col 2 of a 4-wide frame → `err_eol`=1, `frm_done` still after beat 7. Missing tuser on beat 0 → `err_sof`=1. `err_clr` clears both.
- **Timeout:** `timeout_cycles`=20, stop beats after beat 3 → `err_timeout` at stall cycle 20, state WAIT, no `frm_done`. With `timeout_cycles`=0, the same stall causes no error.
- **Overrun and coincidence:** `frm_start` at beat 5 → `err_overrun`, `fsync` next cycle, counters restart. `frm_start` coincident with beat 7 → `frm_done`, no overrun, `fsync` next cycle.
- **Invalid configuration:** `cfg_update` with m_height=0 → `err_cfg`=1, active and shadow geometry unchanged. From reset with no valid config, `enable`+`frm_start` gives no `fsync`.
